muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit with HI/LO result registers; successor to the
//  single-cycle ALU accumulator path. Sits beside the ALU in EX stage; control stalls on Busy.
//  Adds signed/unsigned ops, iterative shift-add/shift-subtract datapath, start/done handshake,
//  MTHI/MTLO writes and divide-by-zero flag.
// PARAMETERS
//  WIDTH  32  operand width; Hi/Lo each WIDTH bits; min 4.
//  CNT_W  $clog2(WIDTH+1)  iteration counter width (derived, do not override).
// PORTS
//  Clock      in   1      single clock; all state updates on rising edge
//  Reset      in   1      synchronous, active-high
//  Start      in   1      request; accepted only when Busy==0
//  Op         in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
//  A          in   WIDTH  multiplicand / dividend / MTHI-MTLO data
//  B          in   WIDTH  multiplier / divisor
//  Busy       out  1      operation in progress
//  Done       out  1      1-cycle pulse: Hi/Lo just updated
//  DivByZero  out  1      set on DIV/DIVU with B==0; held until next accepted Start
//  Hi         out  WIDTH  MUL: upper product; DIV: remainder
//  Lo         out  WIDTH  MUL: lower product; DIV: quotient
// BEHAVIOUR
//  Reset: Busy=0, Done=0, DivByZero=0, Hi=0, Lo=0, counter=0, FSM=IDLE. Reset mid-op aborts, no Done.
//  FSM: IDLE -> (Start & Op in 0..3 & !(div & B==0)) RUN -> (counter==WIDTH) FIX -> IDLE.
//  Accept edge t: operands latched as magnitudes (signed ops: abs value, signs stored), Busy=1.
//  RUN: one bit per cycle, WIDTH cycles (radix-2 shift-add for MUL, restoring shift-sub for DIV).
//  FIX: apply sign; at edge t+WIDTH+1 Hi/Lo written, Done=1 for that cycle, Busy=0.
//  Latency MUL/DIV = WIDTH+1 cycles Start->Done; next Start accepted in the Done cycle.
//  MULT: {Hi,Lo} = signed A * signed B (2*WIDTH bits exact). MULTU: unsigned product.
//  DIV: quotient truncates toward zero; remainder takes dividend sign; |rem| < |B|.
//  DIV MIN/-1: Lo=MIN (wraps), Hi=0; no flag.
//  DIVU: plain unsigned quotient/remainder.
//  Div by zero (Op 2/3, B==0): no RUN; 1 cycle: Hi=A, Lo=all ones, DivByZero=1, Done=1.
//  MTHI/MTLO: 1 cycle; Hi (resp. Lo) = A, other register unchanged, Done=1, Busy never set.
//  Reserved Op with Start: ignored, no state change, no Done.
//  Start while Busy: ignored; operands of in-flight op unaffected by A/B/Op changes.
//  Hi/Lo hold last value throughout RUN/FIX (readers see old results until Done).
//  DivByZero cleared at any accepted Start not itself a div-by-zero.
// TESTING
//  MULT A=-3 B=7 (WIDTH=32) -> Done at t+33, Hi=FFFFFFFF, Lo=FFFFFFEB, Busy high 33 cycles.
//  MULTU A=FFFFFFFF B=FFFFFFFF -> Hi=FFFFFFFE, Lo=00000001.
//  DIV A=-7 B=2 -> Lo=FFFFFFFD (-3), Hi=FFFFFFFF (-1); DIVU A=7 B=2 -> Lo=3, Hi=1.
//  DIV A=80000000 B=FFFFFFFF -> Lo=80000000, Hi=0; DIVU A=5 B=0 -> next cycle Done, Hi=5,
//   Lo=FFFFFFFF, DivByZero=1; following MTLO A=9 -> Lo=9, Hi=5, DivByZero=0.
//  Start MULT, toggle Start/A/B mid-RUN -> ignored, original result; Reset at t+10 -> Busy=0,
//   Hi=Lo=0, no Done pulse; Start next cycle accepted normally.
//  Back-to-back: Start asserted in Done cycle -> accepted, second Done exactly WIDTH+1 later.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Radix-2 shift-add multiply and restoring shift-subtract divide, one bit per cycle.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state;
   logic [CNT_W-1:0]   count;
   logic               is_div;
   logic               neg_res;
   logic               neg_rem;
   logic [WIDTH:0]     work_hi;   // product high half / partial remainder
   logic [WIDTH-1:0]   work_lo;   // multiplier / dividend shifting into quotient
   logic [WIDTH-1:0]   opnd_b;

   logic               op_signed;
   logic               op_div;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] product;
   logic [2*WIDTH-1:0] fix_prod;
   logic [WIDTH-1:0]   fix_quot;
   logic [WIDTH-1:0]   fix_rem;

   assign op_signed = (Op == OP_MULT) || (Op == OP_DIV);
   assign op_div    = (Op == OP_DIV)  || (Op == OP_DIVU);
   assign mag_a     = (op_signed && A[WIDTH-1]) ? -A : A;
   assign mag_b     = (op_signed && B[WIDTH-1]) ? -B : B;

   // The operand magnitudes never exceed 2^(WIDTH-1) for signed ops, so the sum fits in WIDTH+1 bits.
   assign mul_sum   = work_hi + (work_lo[0] ? {1'b0, opnd_b} : '0);
   assign div_shift = {work_hi[WIDTH-1:0], work_lo[WIDTH-1]};
   assign div_ge    = div_shift >= {1'b0, opnd_b};
   assign div_diff  = div_shift - {1'b0, opnd_b};

   assign product   = {work_hi[WIDTH-1:0], work_lo};
   assign fix_prod  = neg_res ? -product : product;
   assign fix_quot  = neg_res ? -work_lo : work_lo;
   assign fix_rem   = neg_rem ? -work_hi[WIDTH-1:0] : work_hi[WIDTH-1:0];

   // NOTE: every register here is state, so all updates are non-blocking; Done defaults low each
   // cycle, which makes it a single-cycle pulse without a separate clear path.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= IDLE;
         count     <= '0;
         is_div    <= 1'b0;
         neg_res   <= 1'b0;
         neg_rem   <= 1'b0;
         work_hi   <= '0;
         work_lo   <= '0;
         opnd_b    <= '0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         DivByZero <= 1'b0;
         Hi        <= '0;
         Lo        <= '0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (Start) begin
                  if (!Op[2]) begin
                     if (op_div && B == '0) begin
                        Hi        <= A;
                        Lo        <= '1;
                        DivByZero <= 1'b1;
                        Done      <= 1'b1;
                     end else begin
                        state     <= RUN;
                        Busy      <= 1'b1;
                        DivByZero <= 1'b0;
                        count     <= '0;
                        is_div    <= op_div;
                        neg_res   <= op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_rem   <= op_signed && A[WIDTH-1];
                        work_hi   <= '0;
                        work_lo   <= mag_a;
                        opnd_b    <= mag_b;
                     end
                  end else if (Op == OP_MTHI) begin
                     Hi        <= A;
                     DivByZero <= 1'b0;
                     Done      <= 1'b1;
                  end else if (Op == OP_MTLO) begin
                     Lo        <= A;
                     DivByZero <= 1'b0;
                     Done      <= 1'b1;
                  end
               end
            end
            RUN: begin
               count <= count + CNT_W'(1);
               if (is_div) begin
                  work_hi <= div_ge ? div_diff : div_shift;
                  work_lo <= {work_lo[WIDTH-2:0], div_ge};
               end else begin
                  work_hi <= {1'b0, mul_sum[WIDTH:1]};
                  work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
               end
               // Leaving on the last iteration means count reads WIDTH while in FIX.
               if (count == CNT_W'(WIDTH - 1)) state <= FIX;
            end
            FIX: begin
               if (is_div) begin
                  Hi <= fix_rem;
                  Lo <= fix_quot;
               end else begin
                  Hi <= fix_prod[2*WIDTH-1:WIDTH];
                  Lo <= fix_prod[WIDTH-1:0];
               end
               Done  <= 1'b1;
               Busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a register model feeds a scoreboard of expected
// Hi/Lo/DivByZero and completion cycle, compared whenever the unit pulses Done.
module tb_muldiv_unit;

   localparam int W = 32;

   logic         Clock;
   logic         Reset;
   logic         Start;
   logic [2:0]   Op;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Busy;
   logic         Done;
   logic         DivByZero;
   logic [W-1:0] Hi;
   logic [W-1:0] Lo;

   muldiv_unit #(.WIDTH(W)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Start     (Start),
      .Op        (Op),
      .A         (A),
      .B         (B),
      .Busy      (Busy),
      .Done      (Done),
      .DivByZero (DivByZero),
      .Hi        (Hi),
      .Lo        (Lo)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      int           done_cycle;
   } exp_t;

   exp_t         sb[$];
   exp_t         mon_e;
   int           cycle = 0;
   int           n_checks = 0;
   int           n_fail = 0;
   logic [W-1:0] m_hi, m_lo, hold_hi, hold_lo;
   logic         m_dbz;

   always @(posedge Clock) cycle <= cycle + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Scoreboard consumer: results are sampled mid-cycle, away from the active edge.
   always @(negedge Clock) begin
      if (Reset === 1'b0 && Done === 1'b1) begin
         if (sb.size() == 0) begin
            check("spurious_done", 64'(Done), 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check("hi", 64'(Hi), 64'(mon_e.hi));
            check("lo", 64'(Lo), 64'(mon_e.lo));
            check("div_by_zero", 64'(DivByZero), 64'(mon_e.dbz));
            check("done_cycle", 64'(cycle), 64'(mon_e.done_cycle));
         end
      end
   end

   // Called one time unit after a rising edge; the request is accepted at the next edge.
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t        e;
      logic [63:0] p;
      longint      q, r;
      bit          push;
      hold_hi = m_hi;
      hold_lo = m_lo;
      push = 1'b1;
      e.hi = m_hi;
      e.lo = m_lo;
      e.dbz = 1'b0;
      e.done_cycle = cycle + 1;
      case (op)
         3'd0, 3'd1: begin
            if (op == 3'd0) p = 64'(longint'($signed(a)) * longint'($signed(b)));
            else            p = {32'd0, a} * {32'd0, b};
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.done_cycle = cycle + 1 + W + 1;
         end
         3'd2, 3'd3: begin
            if (b == '0) begin
               e.hi  = a;
               e.lo  = '1;
               e.dbz = 1'b1;
            end else begin
               if (op == 3'd2) begin
                  q = longint'($signed(a)) / longint'($signed(b));
                  r = longint'($signed(a)) % longint'($signed(b));
               end else begin
                  q = longint'({32'd0, a}) / longint'({32'd0, b});
                  r = longint'({32'd0, a}) % longint'({32'd0, b});
               end
               e.lo = q[31:0];
               e.hi = r[31:0];
               e.done_cycle = cycle + 1 + W + 1;
            end
         end
         3'd4:    e.hi = a;
         3'd5:    e.lo = a;
         default: push = 1'b0;
      endcase
      if (push) begin
         m_hi  = e.hi;
         m_lo  = e.lo;
         m_dbz = e.dbz;
         sb.push_back(e);
      end
      Start = 1'b1;
      Op    = op;
      A     = a;
      B     = b;
      @(posedge Clock);
      #1;
      Start = 1'b0;
   endtask

   // Waits until the scoreboard drains, counting Busy cycles and checking Hi/Lo hold while busy.
   task automatic wait_idle(output int busy_n);
      busy_n = 0;
      for (int i = 0; i < W + 10; i++) begin
         if (sb.size() == 0) break;
         if (Busy === 1'b1) begin
            busy_n++;
            check("hi_hold", 64'(Hi), 64'(hold_hi));
            check("lo_hold", 64'(Lo), 64'(hold_lo));
         end
         @(posedge Clock);
         #1;
      end
      if (sb.size() != 0) begin
         check("done_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int exp_busy);
      int busy_n;
      issue(op, a, b);
      wait_idle(busy_n);
      check("busy_cycles", 64'(busy_n), 64'(exp_busy));
   endtask

   initial begin
      int busy_n;
      Reset = 1'b1;
      Start = 1'b0;
      Op    = '0;
      A     = '0;
      B     = '0;
      m_hi  = '0;
      m_lo  = '0;
      m_dbz = 1'b0;
      hold_hi = '0;
      hold_lo = '0;
      repeat (3) @(posedge Clock);
      #1;
      Reset = 1'b0;

      check("rst_busy", 64'(Busy), 64'd0);
      check("rst_done", 64'(Done), 64'd0);
      check("rst_dbz", 64'(DivByZero), 64'd0);
      check("rst_hi", 64'(Hi), 64'd0);
      check("rst_lo", 64'(Lo), 64'd0);

      // Main function across signed/unsigned multiply and divide, including edge operands.
      run_op(3'd0, -32'sd3, 32'd7, W + 1);
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, W + 1);
      run_op(3'd0, 32'h8000_0000, 32'h8000_0000, W + 1);
      run_op(3'd0, 32'h1234_5678, -32'sd99, W + 1);
      run_op(3'd2, -32'sd7, 32'd2, W + 1);
      run_op(3'd3, 32'd7, 32'd2, W + 1);
      run_op(3'd2, 32'd7, -32'sd2, W + 1);
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, W + 1);
      run_op(3'd3, 32'hFFFF_FFF0, 32'd3, W + 1);
      run_op(3'd2, 32'd3, 32'd10, W + 1);
      for (int i = 0; i < 4; i++) run_op(3'(i), $urandom, $urandom, W + 1);

      // Divide by zero completes in one cycle; the next accepted op clears the flag.
      run_op(3'd3, 32'd5, 32'd0, 0);
      check("dbz_held", 64'(DivByZero), 64'd1);
      run_op(3'd5, 32'd9, 32'd0, 0);
      run_op(3'd2, -32'sd4, 32'd0, 0);
      run_op(3'd4, 32'hCAFE_F00D, 32'd0, 0);

      // Reserved opcodes change nothing and never pulse Done.
      run_op(3'd6, 32'h1111_1111, 32'd1, 0);
      run_op(3'd7, 32'h2222_2222, 32'd2, 0);
      repeat (2) @(posedge Clock);
      #1;
      check("rsvd_hi", 64'(Hi), 64'(m_hi));
      check("rsvd_lo", 64'(Lo), 64'(m_lo));
      check("rsvd_busy", 64'(Busy), 64'd0);

      // Requests and operand changes while busy are ignored.
      issue(3'd0, -32'sd12345, 32'd678);
      repeat (3) @(posedge Clock);
      #1;
      for (int i = 0; i < 5; i++) begin
         Start = 1'b1;
         Op    = 3'(i);
         A     = $urandom;
         B     = (i == 3) ? 32'd0 : $urandom;
         @(posedge Clock);
         #1;
      end
      Start = 1'b0;
      wait_idle(busy_n);

      // Reset mid-operation aborts without a Done; the next Start is accepted normally.
      issue(3'd1, 32'd5, 32'd6);
      repeat (9) @(posedge Clock);
      #1;
      Reset = 1'b1;
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      sb.delete();
      m_hi  = '0;
      m_lo  = '0;
      m_dbz = 1'b0;
      check("abort_busy", 64'(Busy), 64'd0);
      check("abort_done", 64'(Done), 64'd0);
      check("abort_hi", 64'(Hi), 64'd0);
      check("abort_lo", 64'(Lo), 64'd0);
      run_op(3'd1, 32'd5, 32'd6, W + 1);

      // Back-to-back: a Start in the Done cycle is accepted; latency is checked by the scoreboard.
      issue(3'd2, 32'd100, 32'd7);
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < W + 10; i++) begin
            @(posedge Clock);
            #1;
            if (Done === 1'b1) begin
               seen = 1'b1;
               break;
            end
         end
         check("b2b_first_done", 64'(seen), 64'd1);
      end
      issue(3'd0, -32'sd5, -32'sd9);
      wait_idle(busy_n);
      check("b2b_busy", 64'(busy_n), 64'(W + 1));

      repeat (3) @(posedge Clock);
      #1;
      check("final_hi", 64'(Hi), 64'(m_hi));
      check("final_lo", 64'(Lo), 64'(m_lo));
      check("final_dbz", 64'(DivByZero), 64'(m_dbz));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
